// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake, stall and flush.
// Optional stall-cycle counter port stall_cnt when PIPE_STALL_CNT_EN is defined.
module pipe_stage_skid_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              enq, deq;

  // Handshake outputs depend on registered state only; no out_ready/stall path reaches in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (enq) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (enq && deq) begin
            main_d = in_data;
          end else if (enq) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (deq) begin
            main_d  = NOP_VAL;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            main_d  = skid_q;
            skid_d  = NOP_VAL;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating; flush deliberately leaves it alone so stall history survives squashes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && out_valid && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: driver pushes expected payloads, negedge monitor pops on deq.
// Checks stall_cnt as well when PIPE_STALL_CNT_EN is defined.
module tb_pipe_stage_skid_reg;
  localparam int unsigned       DATA_W = 16;
  localparam logic [DATA_W-1:0] NOP    = 16'hDEAD;
  localparam int unsigned       CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [1:0]        occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .NOP_VAL(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the deq condition seen at negedge is what the next rising edge will act on.
  always @(negedge clk) begin
    if (reset && !flush) begin
      if (out_valid && out_ready && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got 0x%0h with nothing expected at %0t", out_data, $time);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL sb_data: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
          end
        end
      end else if (!out_valid) begin
        check("idle_nop", 32'(out_data), 32'(NOP));
      end
    end
  end

  initial begin
    #12;
    check("rst_occ", 32'(occupancy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 32'(NOP));
    reset = 1'b1;
    tick();

    // Back-to-back stream
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h11; exp_q.push_back(16'h11);
    tick();
    check("b2b_lat_11", 32'(out_data), 32'h11);
    in_data = 16'h22; exp_q.push_back(16'h22);
    tick();
    check("b2b_22", 32'(out_data), 32'h22);
    check("b2b_occ", 32'(occupancy), 1);
    check("b2b_in_ready", 32'(in_ready), 1);
    in_data = 16'h33; exp_q.push_back(16'h33);
    tick();
    check("b2b_33", 32'(out_data), 32'h33);
    check("b2b_occ2", 32'(occupancy), 1);
    in_valid = 1'b0;
    tick();
    check("b2b_drained", 32'(occupancy), 0);

    // Skid fill, then stall in FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hA1; exp_q.push_back(16'hA1);
    tick();
    in_data = 16'hA2; exp_q.push_back(16'hA2);
    tick();
    check("skid_occ", 32'(occupancy), 2);
    check("skid_in_ready", 32'(in_ready), 0);
    in_data = 16'hA3; exp_q.push_back(16'hA3);
    tick();
    check("skid_hold_head", 32'(out_data), 32'hA1);
    check("skid_hold_occ", 32'(occupancy), 2);
    stall = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_head", 32'(out_data), 32'hA1);
      check("stall_occ", 32'(occupancy), 2);
    end
`ifdef PIPE_STALL_CNT_EN
    check("stall_cnt4", 32'(stall_cnt), 4);
`endif
    stall = 1'b0;
    tick();
    check("drain_in_ready", 32'(in_ready), 1);
    check("drain_head_a2", 32'(out_data), 32'hA2);
    tick();
    check("drain_head_a3", 32'(out_data), 32'hA3);
    in_valid = 1'b0;
    tick();
    check("drain_empty", 32'(occupancy), 0);

    // Flush of a FULL stage with stall and a new offer
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hD1;
    tick();
    in_data = 16'hD2;
    tick();
    check("fl_pre_occ", 32'(occupancy), 2);
    flush = 1'b1; stall = 1'b1; out_ready = 1'b1; in_data = 16'hBB;
    tick();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 0);
    check("fl_out_data", 32'(out_data), 32'(NOP));
    check("fl_occ", 32'(occupancy), 0);
    tick();
    tick();
    check("fl_no_bb", 32'(out_valid), 0);

    // Asynchronous reset mid-cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hC1;
    tick();
    in_valid = 1'b0;
    check("ar_pre", 32'(out_data), 32'hC1);
    #2 reset = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 0);
    check("ar_out_data", 32'(out_data), 32'(NOP));
    check("ar_occ", 32'(occupancy), 0);
    check("ar_in_ready", 32'(in_ready), 1);
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'hC2; exp_q.push_back(16'hC2);
    tick();
    check("ar_c2", 32'(out_data), 32'hC2);
    in_valid = 1'b0;
    tick();

`ifdef PIPE_STALL_CNT_EN
    check("cnt_after_rst", 32'(stall_cnt), 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hE1;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    check("cnt_sat", 32'(stall_cnt), 32'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    check("cnt_flush_keep", 32'(stall_cnt), 32'hF);
    tick();
`endif

    check("sb_leftover", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
